aq_djpeg_dqt_bank: RTL and testbench
====================================

// Module: aq_djpeg_dqt_bank
// PURPOSE
//  Parametrised quantisation-table store for the JPEG decoder. Receives DQT segment payload bytes
//  straight from the marker parser and decodes Pq/Tq headers itself. Stores up to NUM_TABLES tables,
//  8- or 16-bit precision. Serves registered reads to the dequantiser by (table id, zigzag index).
//  Replaces the fixed two-table, 8-bit-only store.
// PARAMETERS
//  NUM_TABLES  4   tables held; power of 2, range 1..4; TBL_W = max(1,$clog2(NUM_TABLES))
//  DATA_W      16  entry width; 8 (Pq=1 rejected) or 16 (Pq=0 entries zero-extended)
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous, active-high reset
//  seg_start     in   1       pulse: first payload byte of a DQT segment follows (after length field)
//  seg_valid     in   1       payload byte valid
//  seg_data      in   8       payload byte
//  seg_last      in   1       qualifies seg_valid: last payload byte of segment
//  seg_ready     out  1       byte accepted when seg_valid&seg_ready
//  rd_en         in   1       read request
//  rd_table      in   TBL_W   table id (Tq)
//  rd_index      in   6       zigzag coefficient index 0..63
//  rd_data       out  DATA_W  entry, registered
//  rd_valid      out  1       rd_data valid
//  table_loaded  out  NUM_TABLES  bit t=1: table t completely written since last reset/overwrite
//  err           out  1       one-cycle pulse on malformed segment
// BEHAVIOUR
//  Reset: state=IDLE, seg_ready=0, rd_valid=0, rd_data=0, table_loaded=0, err=0.
//   RAM contents are not reset.
//  FSM (advances only on accepted byte unless noted):
//   IDLE : seg_ready=0; seg_start -> HDR.
//   HDR  : byte = {Pq[7:4],Tq[3:0]}; cnt<=0; latch tq,pq; clear table_loaded[Tq].
//          Tq>=NUM_TABLES, Pq>1, or (Pq=1 & DATA_W=8) -> err pulse, DROP.
//          Else seg_last -> err, IDLE. Else Pq=0 -> B8; Pq=1 -> BHI.
//   B8   : write {0,byte} @ {tq,cnt}; cnt++.
//   BHI  : hold MSB; -> BLO.
//   BLO  : write {msb,byte} @ {tq,cnt}; cnt++; else -> BHI.
//   Entry 63 (B8/BLO) : set table_loaded[tq]; seg_last -> IDLE; else -> HDR (next table, same segment).
//   seg_last on any other B8/BHI/BLO byte : err; -> IDLE; table_loaded[tq] stays 0.
//   DROP : consume bytes until seg_last -> IDLE.
//  seg_ready=1 in all states except IDLE. No backpressure otherwise; one byte per cycle sustained.
//  seg_start outside IDLE: abort the current table.
//   If in B8/BHI/BLO, err pulse; table_loaded[tq] stays 0. Then enter HDR.
//  Write address = tq*64+cnt. cnt is 6-bit and never wraps past 63 because of the FSM exit.
//  Read: rd_data/rd_valid registered 1 cycle after rd_en. rd_data holds when rd_en=0; rd_valid=0.
//   Same-cycle read/write to one address returns OLD data.
//   Reads of unloaded tables return stale data; the consumer checks table_loaded.
//  Reset asserted mid-segment: immediate return to IDLE, all loaded bits cleared,
//   partial table discarded logically.
// STRUCTURE
//  aq_djpeg_pkg: DQT_ENTRIES=64, FSM state encodings (IDLE,HDR,B8,BHI,BLO,DROP), PQ_8/PQ_16 consts.
//  Sub-module aq_djpeg_dqt_ram: simple dual-port RAM, NUM_TABLES*64 x DATA_W.
//   1 write port, 1 registered read port, read-old-on-collision.
//  Top holds the FSM, cnt, msb latch, loaded bits and err.
// TESTING
//  1 Pq=0 Tq=1, bytes 1..64, seg_last on 64th -> table_loaded=4'b0010;
//    rd(1,0)=1, rd(1,63)=64, each 1 cycle later.
//  2 One segment with two tables: Tq=0 (Pq=0, all 0x10) then Tq=3 (Pq=1, pairs 0x01,0x02)
//    -> loaded=4'b1001; rd(0,5)=0x0010, rd(3,5)=0x0102.
//  3 Header 0x05 with NUM_TABLES=4 -> err pulse 1 cycle; remaining bytes dropped; loaded unchanged.
//    DATA_W=8 with header 0x10 -> err.
//  4 seg_last on 40th entry of Tq=2 -> err; loaded[2]=0; next good segment loads normally.
//  5 Reload Tq=0 while reading it: loaded[0] falls at header and rises after entry 63.
//    Same-cycle rd/wr of addr 7 returns old value.
//  6 rst pulsed mid-table -> seg_ready=0 and loaded=0 asynchronously; next seg_start accepted.

Source files
------------

// File: rtl/aq_djpeg_dqt_bank_pkg.sv
`default_nettype none
// ==== aq_djpeg_pkg : shared constants and FSM encoding for the DQT table store (rev 1.0) ====

package aq_djpeg_pkg;

    localparam int         DQT_ENTRIES = 64;
    localparam logic [3:0] PQ_8        = 4'd0;
    localparam logic [3:0] PQ_16       = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_B8   = 3'd2,
        ST_BHI  = 3'd3,
        ST_BLO  = 3'd4,
        ST_DROP = 3'd5
    } dqt_state_e;

    function automatic int tbl_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aq_djpeg_dqt_bank_if.sv
`default_nettype none
// ==== aq_djpeg_dqt_if : DQT payload stream plus table read port (rev 1.0) ====

interface aq_djpeg_dqt_if #(
    parameter int NUM_TABLES = 4,
    parameter int DATA_W     = 16
);
    import aq_djpeg_pkg::*;

    localparam int TBL_W = tbl_width(NUM_TABLES);

    logic                  seg_start;
    logic                  seg_valid;
    logic [7:0]            seg_data;
    logic                  seg_last;
    logic                  seg_ready;
    logic                  rd_en;
    logic [TBL_W-1:0]      rd_table;
    logic [5:0]            rd_index;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [NUM_TABLES-1:0] table_loaded;
    logic                  err;

    modport master (
        output seg_start, seg_valid, seg_data, seg_last, rd_en, rd_table, rd_index,
        input  seg_ready, rd_data, rd_valid, table_loaded, err
    );

    modport slave (
        input  seg_start, seg_valid, seg_data, seg_last, rd_en, rd_table, rd_index,
        output seg_ready, rd_data, rd_valid, table_loaded, err
    );

endinterface

`default_nettype wire

// File: rtl/aq_djpeg_dqt_bank_ram.sv
`default_nettype none
// ==== aq_djpeg_dqt_ram : simple dual-port table RAM, registered read, read-old on collision (rev 1.0) ====

module aq_djpeg_dqt_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    input  wire logic              rd_en_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    output      logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; the array itself keeps stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/aq_djpeg_dqt_bank.sv
`default_nettype none
// ==== aq_djpeg_dqt_bank : DQT segment decoder and multi-table quantisation store (rev 1.0) ====

module aq_djpeg_dqt_bank
    import aq_djpeg_pkg::*;
#(
    parameter int NUM_TABLES = 4,
    parameter int DATA_W     = 16
) (
    input wire logic      clk,
    input wire logic      rst,
    aq_djpeg_dqt_if.slave dqt
);

    localparam int TBL_W  = tbl_width(NUM_TABLES);
    localparam int ADDR_W = TBL_W + 6;

    dqt_state_e            state_q;
    logic [5:0]            cnt_q;
    logic [TBL_W-1:0]      tq_q;
    logic [NUM_TABLES-1:0] loaded_q;
    logic                  err_q;
    logic                  rd_valid_q;

    logic                  w_accept;
    logic                  w_byte;
    logic [3:0]            w_hdr_tq;
    logic [3:0]            w_hdr_pq;
    logic                  w_tq_ok;
    logic                  w_pq_ok;
    logic                  w_wr_en;
    logic [DATA_W-1:0]     w_wr_data;

    assign w_accept = dqt.seg_valid && (state_q != ST_IDLE);
    // A seg_start in the same cycle pre-empts the byte, so it is neither decoded nor written.
    assign w_byte   = w_accept && !dqt.seg_start;
    assign w_hdr_tq = dqt.seg_data[3:0];
    assign w_hdr_pq = dqt.seg_data[7:4];
    assign w_tq_ok  = 32'(w_hdr_tq) < NUM_TABLES;
    assign w_pq_ok  = (w_hdr_pq == PQ_8) || ((w_hdr_pq == PQ_16) && (DATA_W == 16));
    assign w_wr_en  = w_byte && ((state_q == ST_B8) || (state_q == ST_BLO));

    generate
        if (DATA_W == 16) begin : g_wide
            logic [7:0] msb_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    msb_q <= 8'h00;
                end else if (w_byte && (state_q == ST_BHI)) begin
                    msb_q <= dqt.seg_data;
                end
            end

            assign w_wr_data = (state_q == ST_BLO) ? {msb_q, dqt.seg_data}
                                                   : {8'h00, dqt.seg_data};
        end else begin : g_narrow
            assign w_wr_data = dqt.seg_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            tq_q     <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (dqt.seg_start) begin
                if (state_q inside {ST_B8, ST_BHI, ST_BLO}) begin
                    err_q <= 1'b1;
                end
                state_q <= ST_HDR;
            end else if (w_accept) begin
                case (state_q)
                    ST_HDR: begin
                        cnt_q <= 6'd0;
                        tq_q  <= w_hdr_tq[TBL_W-1:0];
                        if (w_tq_ok) begin
                            loaded_q[w_hdr_tq[TBL_W-1:0]] <= 1'b0;
                        end
                        if (!w_tq_ok || !w_pq_ok) begin
                            err_q   <= 1'b1;
                            state_q <= dqt.seg_last ? ST_IDLE : ST_DROP;
                        end else if (dqt.seg_last) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= (w_hdr_pq == PQ_16) ? ST_BHI : ST_B8;
                        end
                    end
                    ST_B8, ST_BLO: begin
                        if (cnt_q == 6'd63) begin
                            loaded_q[tq_q] <= 1'b1;
                            state_q        <= dqt.seg_last ? ST_IDLE : ST_HDR;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                            if (dqt.seg_last) begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end else if (state_q == ST_BLO) begin
                                state_q <= ST_BHI;
                            end
                        end
                    end
                    ST_BHI: begin
                        if (dqt.seg_last) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_BLO;
                        end
                    end
                    ST_DROP: begin
                        if (dqt.seg_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= dqt.rd_en;
        end
    end

    aq_djpeg_dqt_ram #(
        .DEPTH  (NUM_TABLES * DQT_ENTRIES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_wr_en),
        .wr_addr_i ({tq_q, cnt_q}),
        .wr_data_i (w_wr_data),
        .rd_en_i   (dqt.rd_en),
        .rd_addr_i ({dqt.rd_table, dqt.rd_index}),
        .rd_data_o (dqt.rd_data)
    );

    assign dqt.seg_ready    = (state_q != ST_IDLE);
    assign dqt.rd_valid     = rd_valid_q;
    assign dqt.table_loaded = loaded_q;
    assign dqt.err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_aq_djpeg_dqt_bank.sv
`default_nettype none
// ==== tb_aq_djpeg_dqt_bank : randomized table loads checked against a per-table array model (rev 1.0) ====

module tb_aq_djpeg_dqt_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aq_djpeg_dqt_if #(.NUM_TABLES(4), .DATA_W(16)) dif ();
    aq_djpeg_dqt_if #(.NUM_TABLES(2), .DATA_W(8))  nif ();

    aq_djpeg_dqt_bank #(.NUM_TABLES(4), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .dqt (dif.slave)
    );

    aq_djpeg_dqt_bank #(.NUM_TABLES(2), .DATA_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .dqt (nif.slave)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] model_mem [4][64];
    bit          model_wr  [4][64];
    logic [3:0]  model_loaded;
    logic [15:0] tbl [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seg();
        dif.seg_start = 1'b1;
        tick();
        dif.seg_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        dif.seg_valid = 1'b1;
        dif.seg_data  = b;
        dif.seg_last  = last;
        tick();
        dif.seg_valid = 1'b0;
        dif.seg_last  = 1'b0;
    endtask

    task automatic send_table(input int tq, input int pq, input int n, input bit last, input string tag);
        logic [3:0] t4;
        logic [3:0] p4;
        bit         lb;
        bit         exp_err;
        t4 = tq[3:0];
        p4 = pq[3:0];
        send_byte({p4, t4}, 1'b0);
        if (tq < 4) model_loaded[tq] = 1'b0;
        for (int i = 0; i < n; i++) begin
            lb = last && (i == n - 1);
            if (pq == 0) begin
                send_byte(tbl[i][7:0], lb);
                model_mem[tq][i] = {8'h00, tbl[i][7:0]};
            end else begin
                send_byte(tbl[i][15:8], 1'b0);
                send_byte(tbl[i][7:0], lb);
                model_mem[tq][i] = tbl[i];
            end
            model_wr[tq][i] = 1'b1;
        end
        if (n == 64) model_loaded[tq] = 1'b1;
        exp_err = last && (n < 64);
        n_vec++;
        if (dif.err !== exp_err) begin
            n_bad++;
            $display("FAIL %s err: got %b expected %b", tag, dif.err, exp_err);
        end
        n_vec++;
        if (dif.table_loaded !== model_loaded) begin
            n_bad++;
            $display("FAIL %s loaded: got %b expected %b", tag, dif.table_loaded, model_loaded);
        end
    endtask

    task automatic do_read(input int tq, input int idx, input logic [15:0] exp, input string tag);
        dif.rd_en    = 1'b1;
        dif.rd_table = 2'(tq);
        dif.rd_index = 6'(idx);
        tick();
        dif.rd_en = 1'b0;
        n_vec++;
        if (dif.rd_valid !== 1'b1 || dif.rd_data !== exp) begin
            n_bad++;
            $display("FAIL %s rd(%0d,%0d): got valid=%b data=%h expected valid=1 data=%h",
                     tag, tq, idx, dif.rd_valid, dif.rd_data, exp);
        end
        tick();
        n_vec++;
        if (dif.rd_valid !== 1'b0 || dif.rd_data !== exp) begin
            n_bad++;
            $display("FAIL %s hold(%0d,%0d): got valid=%b data=%h expected valid=0 data=%h",
                     tag, tq, idx, dif.rd_valid, dif.rd_data, exp);
        end
    endtask

    task automatic test_reset();
        dif.seg_start = 0; dif.seg_valid = 0; dif.seg_data = 0; dif.seg_last = 0;
        dif.rd_en = 0; dif.rd_table = 0; dif.rd_index = 0;
        nif.seg_start = 0; nif.seg_valid = 0; nif.seg_data = 0; nif.seg_last = 0;
        nif.rd_en = 0; nif.rd_table = 0; nif.rd_index = 0;
        model_loaded = 4'b0000;
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 64; i++) model_wr[t][i] = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if ({dif.seg_ready, dif.rd_valid, dif.rd_data, dif.table_loaded, dif.err} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset: got ready=%b rv=%b rd=%h loaded=%b err=%b expected all zero",
                     dif.seg_ready, dif.rd_valid, dif.rd_data, dif.table_loaded, dif.err);
        end
        n_vec++;
        if ({nif.seg_ready, nif.rd_valid, nif.rd_data, nif.table_loaded, nif.err} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset8: got ready=%b rv=%b rd=%h loaded=%b err=%b expected all zero",
                     nif.seg_ready, nif.rd_valid, nif.rd_data, nif.table_loaded, nif.err);
        end
    endtask

    task automatic test_single_table();
        for (int i = 0; i < 64; i++) tbl[i] = 16'(i + 1);
        start_seg();
        send_table(1, 0, 64, 1'b1, "single");
        n_vec++;
        if (dif.table_loaded !== 4'b0010 || dif.seg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single end: got loaded=%b ready=%b expected loaded=0010 ready=0",
                     dif.table_loaded, dif.seg_ready);
        end
        do_read(1, 0, 16'd1, "single");
        do_read(1, 63, 16'd64, "single");
    endtask

    task automatic test_two_tables();
        for (int i = 0; i < 64; i++) tbl[i] = 16'h0010;
        start_seg();
        send_table(0, 0, 64, 1'b0, "two_a");
        for (int i = 0; i < 64; i++) tbl[i] = 16'h0102;
        send_table(3, 1, 64, 1'b1, "two_b");
        do_read(0, 5, 16'h0010, "two");
        do_read(3, 5, 16'h0102, "two");
    endtask

    task automatic test_bad_header();
        start_seg();
        send_byte(8'h05, 1'b0);
        n_vec++;
        if (dif.err !== 1'b1) begin
            n_bad++;
            $display("FAIL badhdr err: got %b expected 1", dif.err);
        end
        send_byte(8'h00, 1'b0);
        n_vec++;
        if (dif.err !== 1'b0) begin
            n_bad++;
            $display("FAIL badhdr pulse: got %b expected 0", dif.err);
        end
        for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h41), i == 2);
        n_vec++;
        if (dif.seg_ready !== 1'b0 || dif.table_loaded !== model_loaded || dif.err !== 1'b0) begin
            n_bad++;
            $display("FAIL badhdr end: got ready=%b loaded=%b err=%b expected ready=0 loaded=%b err=0",
                     dif.seg_ready, dif.table_loaded, dif.err, model_loaded);
        end
    endtask

    task automatic test_narrow();
        logic [7:0] nb [64];
        int         k;
        nif.seg_start = 1'b1; tick(); nif.seg_start = 1'b0;
        nif.seg_valid = 1'b1; nif.seg_data = 8'h10; nif.seg_last = 1'b0;
        tick();
        n_vec++;
        if (nif.err !== 1'b1) begin
            n_bad++;
            $display("FAIL narrow pq1 err: got %b expected 1", nif.err);
        end
        nif.seg_data = 8'hAA; nif.seg_last = 1'b1;
        tick();
        nif.seg_valid = 1'b0; nif.seg_last = 1'b0;
        n_vec++;
        if (nif.err !== 1'b0 || nif.seg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL narrow drop: got err=%b ready=%b expected err=0 ready=0", nif.err, nif.seg_ready);
        end
        nif.seg_start = 1'b1; tick(); nif.seg_start = 1'b0;
        nif.seg_valid = 1'b1; nif.seg_data = 8'h01;
        tick();
        for (int i = 0; i < 64; i++) begin
            nb[i] = 8'($urandom);
            nif.seg_data = nb[i];
            nif.seg_last = (i == 63);
            tick();
        end
        nif.seg_valid = 1'b0; nif.seg_last = 1'b0;
        n_vec++;
        if (nif.table_loaded !== 2'b10 || nif.err !== 1'b0) begin
            n_bad++;
            $display("FAIL narrow load: got loaded=%b err=%b expected loaded=10 err=0", nif.table_loaded, nif.err);
        end
        for (int r = 0; r < 3; r++) begin
            k = (r == 0) ? 0 : (r == 1) ? 63 : int'($urandom_range(1, 62));
            nif.rd_en = 1'b1; nif.rd_table = 1'b1; nif.rd_index = 6'(k);
            tick();
            nif.rd_en = 1'b0;
            n_vec++;
            if (nif.rd_valid !== 1'b1 || nif.rd_data !== nb[k]) begin
                n_bad++;
                $display("FAIL narrow rd(1,%0d): got valid=%b data=%h expected valid=1 data=%h",
                         k, nif.rd_valid, nif.rd_data, nb[k]);
            end
        end
    endtask

    task automatic test_truncated();
        for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
        start_seg();
        send_table(2, 0, 40, 1'b1, "trunc");
        tick();
        n_vec++;
        if (dif.err !== 1'b0 || dif.table_loaded[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL trunc after: got err=%b loaded2=%b expected err=0 loaded2=0",
                     dif.err, dif.table_loaded[2]);
        end
        for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
        start_seg();
        send_table(2, 1, 64, 1'b1, "trunc_reload");
        do_read(2, 0, model_mem[2][0], "trunc_reload");
        do_read(2, 39, model_mem[2][39], "trunc_reload");
        do_read(2, 63, model_mem[2][63], "trunc_reload");
    endtask

    task automatic test_reload_collision();
        logic [15:0] old7;
        logic [7:0]  nv;
        old7 = model_mem[0][7];
        start_seg();
        send_byte(8'h00, 1'b0);
        model_loaded[0] = 1'b0;
        n_vec++;
        if (dif.table_loaded !== model_loaded) begin
            n_bad++;
            $display("FAIL reload hdr: got loaded=%b expected %b", dif.table_loaded, model_loaded);
        end
        for (int i = 0; i < 64; i++) begin
            nv = 8'(i + 8'h80);
            if (i == 7) begin
                dif.rd_en = 1'b1; dif.rd_table = 2'd0; dif.rd_index = 6'd7;
            end
            send_byte(nv, i == 63);
            model_mem[0][i] = {8'h00, nv};
            if (i == 7) begin
                dif.rd_en = 1'b0;
                n_vec++;
                if (dif.rd_valid !== 1'b1 || dif.rd_data !== old7) begin
                    n_bad++;
                    $display("FAIL collision: got valid=%b data=%h expected valid=1 data=%h",
                             dif.rd_valid, dif.rd_data, old7);
                end
            end
            if (i == 62) begin
                n_vec++;
                if (dif.table_loaded[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reload early: got loaded0=%b expected 0", dif.table_loaded[0]);
                end
            end
        end
        model_loaded[0] = 1'b1;
        n_vec++;
        if (dif.table_loaded !== model_loaded) begin
            n_bad++;
            $display("FAIL reload done: got loaded=%b expected %b", dif.table_loaded, model_loaded);
        end
        do_read(0, 7, model_mem[0][7], "reload");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
        start_seg();
        send_table(2, 0, 10, 1'b0, "arst_part");
        #2;
        rst = 1'b1;
        #1;
        model_loaded = 4'b0000;
        n_vec++;
        if (dif.seg_ready !== 1'b0 || dif.table_loaded !== 4'b0000) begin
            n_bad++;
            $display("FAIL async rst: got ready=%b loaded=%b expected ready=0 loaded=0000",
                     dif.seg_ready, dif.table_loaded);
        end
        tick();
        rst = 1'b0;
        tick();
        start_seg();
        n_vec++;
        if (dif.seg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL arst restart: got ready=%b expected 1", dif.seg_ready);
        end
        for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
        send_table(2, 1, 64, 1'b1, "arst_load");
        do_read(2, 9, model_mem[2][9], "arst");
    endtask

    task automatic test_random();
        int ntab;
        int tq;
        int idx;
        for (int s = 0; s < 8; s++) begin
            ntab = int'($urandom_range(1, 2));
            start_seg();
            for (int t = 0; t < ntab; t++) begin
                for (int i = 0; i < 64; i++) tbl[i] = 16'($urandom);
                send_table(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 64,
                           t == ntab - 1, "rand_load");
            end
            for (int r = 0; r < 4; r++) begin
                tq  = int'($urandom_range(0, 3));
                idx = int'($urandom_range(0, 63));
                if (model_wr[tq][idx]) do_read(tq, idx, model_mem[tq][idx], "rand");
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_table();
        test_two_tables();
        test_bad_header();
        test_narrow();
        test_truncated();
        test_reload_collision();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
